// File: rtl/tmds_pkg.sv
// Shared HDMI/TMDS definitions: symbol width, the four control-period
// symbols, the TMDS clock-channel pattern and the {ch2,ch1,ch0} word triple.
package tmds_pkg;
   localparam int TMDS_W = 10;

   // Control-period symbols, named by {c1,c0}
   localparam logic [TMDS_W-1:0] CTRL_SYM_00 = 10'b1101010100;
   localparam logic [TMDS_W-1:0] CTRL_SYM_01 = 10'b0010101011;
   localparam logic [TMDS_W-1:0] CTRL_SYM_10 = 10'b0101010100;
   localparam logic [TMDS_W-1:0] CTRL_SYM_11 = 10'b1010101011;

   // Clock channel: five ones then five zeros, sent LSB first
   localparam logic [TMDS_W-1:0] TMDS_CLK_PAT = 10'b0000011111;

   typedef struct packed {
      logic [TMDS_W-1:0] ch2;
      logic [TMDS_W-1:0] ch1;
      logic [TMDS_W-1:0] ch0;
   } tmds_triple_t;

   function automatic tmds_triple_t idle_triple(input logic [TMDS_W-1:0] sym);
      return '{ch2: sym, ch1: sym, ch0: sym};
   endfunction
endpackage

// File: rtl/tmds_word_fifo.sv
// Synchronous FIFO of TMDS word triples.
// Ports: clk/rst (async, active high); flush empties the FIFO and wins over
// push/pop; push ignored when full, pop ignored when empty; rdata is the head
// entry (valid when !empty); empty/full/level report occupancy.
module tmds_word_fifo
   import tmds_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = AW + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               push,
   input  logic               pop,
   input  tmds_triple_t       wdata,
   output tmds_triple_t       rdata,
   output logic               empty,
   output logic               full,
   output logic [LW-1:0]      level
);
   tmds_triple_t  mem_q [DEPTH];
   tmds_triple_t  mem_d [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [LW-1:0] level_q, level_d;
   logic          do_push, do_pop;

   assign empty = (level_q == '0);
   assign full  = (level_q == LW'(DEPTH));
   assign level = level_q;
   assign rdata = mem_q[rd_q];

   always_comb begin
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      level_d = level_q;
      do_push = push && !full;
      do_pop  = pop && !empty;
      if (flush) begin
         wr_d    = '0;
         rd_d    = '0;
         level_d = '0;
      end else begin
         // DEPTH is a power of two, so pointers wrap naturally
         if (do_push) begin
            mem_d[wr_q] = wdata;
            wr_d        = wr_q + AW'(1);
         end
         if (do_pop) rd_d = rd_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q   <= '{default: '0};
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         level_q <= level_d;
      end
   end
endmodule

// File: rtl/tmds_serializer.sv
// 10:1 TMDS serializer for three data channels plus the TMDS clock channel.
// Ports: clk (10x pixel), rst (async, active high); en gates the link (low =
// idle symbols, FIFO flushed); in_valid/in_ready/in_ch0..2 accept word
// triples; pix_ce strobes on the load slot; ser_ch0..2/ser_clk are the serial
// bits (LSB first); fifo_level and underflow_cnt are status.
module tmds_serializer
   import tmds_pkg::*;
#(
   parameter int                FIFO_DEPTH  = 4,
   parameter logic [TMDS_W-1:0] IDLE_SYMBOL = CTRL_SYM_00
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [TMDS_W-1:0]             in_ch0,
   input  logic [TMDS_W-1:0]             in_ch1,
   input  logic [TMDS_W-1:0]             in_ch2,
   output logic                          pix_ce,
   output logic                          ser_ch0,
   output logic                          ser_ch1,
   output logic                          ser_ch2,
   output logic                          ser_clk,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [7:0]                    underflow_cnt
);
   logic [3:0]        bit_cnt_q, bit_cnt_d;
   tmds_triple_t      shift_q, shift_d;
   logic [TMDS_W-1:0] shift_clk_q, shift_clk_d;
   logic              primed_q, primed_d;
   logic [7:0]        ucnt_q, ucnt_d;

   logic              load, fifo_pop, fifo_push, fifo_empty, fifo_full;
   tmds_triple_t      fifo_rdata, fifo_wdata;

   assign load       = (bit_cnt_q == 4'd9);
   assign fifo_pop   = load && en && !fifo_empty;
   assign fifo_push  = in_valid && in_ready && en;
   assign fifo_wdata = '{ch2: in_ch2, ch1: in_ch1, ch0: in_ch0};
   assign in_ready   = !fifo_full;

   tmds_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (!en),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata (fifo_wdata),
      .rdata (fifo_rdata),
      .empty (fifo_empty),
      .full  (fifo_full),
      .level (fifo_level)
   );

   always_comb begin
      bit_cnt_d   = load ? 4'd0 : bit_cnt_q + 4'd1;
      shift_d.ch0 = {1'b0, shift_q.ch0[TMDS_W-1:1]};
      shift_d.ch1 = {1'b0, shift_q.ch1[TMDS_W-1:1]};
      shift_d.ch2 = {1'b0, shift_q.ch2[TMDS_W-1:1]};
      shift_clk_d = {1'b0, shift_clk_q[TMDS_W-1:1]};
      primed_d    = primed_q;
      ucnt_d      = ucnt_q;
      if (load) begin
         shift_clk_d = TMDS_CLK_PAT;
         if (fifo_pop) begin
            shift_d  = fifo_rdata;
            primed_d = 1'b1;
         end else begin
            shift_d = idle_triple(IDLE_SYMBOL);
            // Only starvation after real traffic has started is an underflow
            if (en && primed_q && ucnt_q != 8'hFF) ucnt_d = ucnt_q + 8'd1;
         end
      end
      if (!en) primed_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt_q   <= 4'd0;
         shift_q     <= idle_triple(IDLE_SYMBOL);
         shift_clk_q <= TMDS_CLK_PAT;
         primed_q    <= 1'b0;
         ucnt_q      <= 8'd0;
      end else begin
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         shift_clk_q <= shift_clk_d;
         primed_q    <= primed_d;
         ucnt_q      <= ucnt_d;
      end
   end

   // Outputs are the shift-register LSBs directly
   assign pix_ce        = load;
   assign ser_ch0       = shift_q.ch0[0];
   assign ser_ch1       = shift_q.ch1[0];
   assign ser_ch2       = shift_q.ch2[0];
   assign ser_clk       = shift_clk_q[0];
   assign underflow_cnt = ucnt_q;
endmodule

// File: doc/tmds_serializer.md
# tmds_serializer

Bit-rate 10:1 serializer for the HDMI output path; sits directly downstream of the three TMDS channel encoders and upstream of the LVDS output buffers. Accepts 10-bit TMDS words for channels 0/1/2 through a valid/ready FIFO, shifts them out LSB-first, and generates the matching TMDS clock pattern and a pixel-rate strobe. Empty-FIFO slots are filled with a blanking control symbol and counted, so the link never carries garbage.

## Interface
- FIFO_DEPTH, 4: word FIFO entries (power of 2, ≥2); each entry is one 30-bit {ch2,ch1,ch0} triple.
- IDLE_SYMBOL, 10'b1101010100: symbol sent on all data channels when no word is available (control period, c0=c1=0).
- clk  in  1  bit clock, 10× pixel rate.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  serializer enable; low = idle symbols, FIFO flushed.
- in_valid  in  1  word triple valid.
- in_ready  out  1  FIFO can accept (= !full).
- in_ch0, in_ch1, in_ch2  in  10 each  TMDS words, blue/green/red.
- pix_ce  out  1  one-cycle strobe every 10 cycles, at word-load slot.
- ser_ch0, ser_ch1, ser_ch2  out  1 each  serial data bit.
- ser_clk  out  1  serial TMDS clock bit.
- fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- underflow_cnt  out  8  saturating count of idle substitutions while primed.

## Operation
- Reset values: bit_cnt=0, all data shift regs=IDLE_SYMBOL, clock shift reg=10'b0000011111, FIFO empty, primed=0, underflow_cnt=0; hence ser_chN=0, ser_clk=1, pix_ce=0, in_ready=1, fifo_level=0.
- bit_cnt counts 0..9 and wraps, free-running regardless of en. pix_ce = (bit_cnt==9).
- Non-load cycles: each shift reg shifts right by one, MSB filled with 0; ser_chN = shift_chN[0], ser_clk = shift_clk[0] (direct register bits, no extra stage).
- Load cycle (bit_cnt==9): clock shift reg reloads 10'b0000011111. Data regs load:
  - en=1, FIFO non-empty: head triple, pop; primed←1.
  - en=1, FIFO empty: IDLE_SYMBOL; if primed, underflow_cnt+1 saturating at 255.
  - en=0: IDLE_SYMBOL, no count.
- Push when in_valid && in_ready && en. in_ready = !full; a full FIFO refuses a push even if a pop occurs the same cycle. Push and pop on a non-full, non-empty FIFO in one cycle: level unchanged.
- en=0: FIFO flushed synchronously (level→0), primed←0, in_ready stays !full (=1 after flush) but pushes are ignored. underflow_cnt holds; cleared only by rst.
- Words are output LSB first: bit 0 of the triple appears on the cycle after the load edge.

## Timing
- Word pushed at cycle t into empty FIFO with en=1: popped at next cycle with bit_cnt==9 (≥ t+1); its bit k drives ser_chN during the k-th cycle after that load edge, k=0..9.
- Throughput: one triple per 10 clk cycles; ser_clk high for bits 0..4, low for 5..9 of every word, aligned with data words.
- rst mid-word: all state returns to reset values asynchronously; the partial word is lost and the first post-reset load is at bit_cnt==9 (cycle 10 after release).
- en toggling mid-word: the word already in the shift regs completes; the effect applies at the next load.

## Structure
- Shared HDMI package: IDLE_SYMBOL control constants (all four c1c0 symbols), TMDS clock pattern 10'b0000011111, word width 10.
- One sub-module natural: tmds_word_fifo (synchronous FIFO, 30-bit entries, push/pop/flush/level). Counter, load logic and shift regs stay in the top.

## Test plan
- Reset: hold rst, release -> ser_clk=1, ser_chN=0, in_ready=1, fifo_level=0, pix_ce first high 10 cycles after release with bit_cnt sequence 0..9.
- Single word: push ch0=10'h3A5, ch1=10'h155, ch2=10'h2AA -> after next load ser_ch0 emits 1,0,1,0,0,1,0,1,1,1 LSB first; others match their values; underflow_cnt stays 0 until a later load finds the FIFO empty, then becomes 1.
- Backpressure: en=1, push every cycle -> in_ready drops after FIFO_DEPTH pushes (level=4), rises on pop; no word lost or duplicated over 100 random triples compared against a scoreboard.
- Underflow saturation: prime with one word, then starve 300 word slots -> idle symbol 1101010100 on all channels, underflow_cnt=255.
- en deassert with level=3 mid-word -> current word completes, next loads IDLE_SYMBOL, fifo_level=0, primed cleared (no underflow counting after re-enable until first pop).
- Async rst at bit_cnt=4 mid-word -> outputs immediately return to reset values; clock pattern resumes aligned to new load slot.
